// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller: turns a read/write command into a 3-byte frame
// for an SPI byte engine, collects the 3 echoed bytes and returns a one-cycle response.
module spi_reg_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic [7:0]  spi_tx_data,
    output logic        spi_tx_valid,
    input  logic        spi_tx_ready,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_rx_valid
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rw;
    logic [6:0]      r_addr;
    logic [15:0]     r_wdata;
    logic [1:0]      r_tx_cnt;
    logic [1:0]      r_rx_cnt;
    logic [WD_W-1:0] r_wdog;
    logic [15:0]     r_rdata;
    logic            r_error;

    logic            w_accept;
    logic            w_busy;
    logic            w_tx_hs;
    logic            w_rx_stb;
    logic            w_progress;
    logic            w_timeout;
    logic [1:0]      w_rx_cnt_nxt;
    logic [WD_W-1:0] w_wdog_inc;

    function automatic logic [7:0] frame_byte(input logic rw, input logic [6:0] addr,
                                              input logic [15:0] wdata, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {rw, addr};
            2'd1:    b = rw ? 8'h00 : wdata[15:8];
            2'd2:    b = rw ? 8'h00 : wdata[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_accept     = (r_state == IDLE) && cmd_valid;
    assign w_busy       = (r_state == SEND) || (r_state == WAIT_RX);
    assign w_tx_hs      = (r_state == SEND) && spi_tx_ready;
    // A fourth strobe cannot occur in a well-formed frame; the count saturates at 3.
    assign w_rx_stb     = w_busy && spi_rx_valid && (r_rx_cnt != 2'd3);
    assign w_rx_cnt_nxt = r_rx_cnt + {1'b0, w_rx_stb};
    assign w_progress   = w_tx_hs || w_rx_stb;
    assign w_wdog_inc   = r_wdog + WD_W'(1);
    assign w_timeout    = w_busy && !w_progress && (w_wdog_inc == WD_W'(TIMEOUT_CYCLES));

    assign cmd_ready    = (r_state == IDLE);
    assign spi_tx_valid = (r_state == SEND);
    assign spi_tx_data  = (r_state == SEND) ? frame_byte(r_rw, r_addr, r_wdata, r_tx_cnt) : 8'h00;
    assign rsp_valid    = (r_state == RESP);
    assign rsp_rdata    = r_rdata;
    assign rsp_error    = r_error;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_nxt = SEND;
            SEND: begin
                if (w_timeout)
                    w_state_nxt = RESP;
                else if (w_tx_hs && (r_tx_cnt == 2'd2))
                    w_state_nxt = (w_rx_cnt_nxt == 2'd3) ? RESP : WAIT_RX;
            end
            WAIT_RX: if (w_timeout || (w_rx_cnt_nxt == 2'd3)) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tx_cnt <= 2'd0;
            r_rx_cnt <= 2'd0;
            r_wdog   <= '0;
            r_rdata  <= 16'h0000;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tx_cnt <= 2'd0;
                r_rx_cnt <= 2'd0;
                r_wdog   <= '0;
                r_error  <= 1'b0;
            end else begin
                if (w_tx_hs)
                    r_tx_cnt <= r_tx_cnt + 2'd1;
                r_rx_cnt <= w_rx_cnt_nxt;
                // rx byte0 is the turnaround byte and is discarded
                if (w_rx_stb) begin
                    case (r_rx_cnt)
                        2'd1:    r_rdata[15:8] <= spi_rx_data;
                        2'd2:    r_rdata[7:0]  <= spi_rx_data;
                        default: ;
                    endcase
                end
                r_wdog <= (!w_busy || w_progress) ? '0 : w_wdog_inc;
                if (w_busy && (w_state_nxt == RESP))
                    r_error <= w_timeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rw    <= cmd_rw;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: write, read, tx back-pressure, watchdog timeout
// and mid-transaction reset, all with hand-computed expected values.
module tb_spi_reg_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic [7:0]  spi_tx_data;
    logic        spi_tx_valid;
    logic        spi_tx_ready;
    logic [7:0]  spi_rx_data;
    logic        spi_rx_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    spi_reg_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_tx_ready(spi_tx_ready),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait transaction with each rx byte aligned to its tx handshake.
    task automatic xact(input string tag, input logic rw, input logic [6:0] addr,
                        input logic [15:0] wd, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [15:0] exp_rd, input logic hold);
        logic [7:0] e [3];
        logic [7:0] r [3];
        e = '{e0, e1, e2};
        r = '{r0, r1, r2};
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; spi_tx_ready = 1'b1;
        chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        step();
        if (!hold) cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
            chk({tag, "_tx_valid"}, 32'(spi_tx_valid), 32'd1);
            chk({tag, "_tx_data"}, 32'(spi_tx_data), 32'(e[k]));
            spi_rx_valid = 1'b1; spi_rx_data = r[k];
            step();
        end
        spi_rx_valid = 1'b0; cmd_valid = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        chk({tag, "_tx_valid_resp"}, 32'(spi_tx_valid), 32'd0);
        step();
        chk({tag, "_rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_back_idle"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_no_second_cmd"}, 32'(spi_tx_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'h00; cmd_wdata = 16'h0000;
        spi_tx_ready = 1'b0; spi_rx_data = 8'h00; spi_rx_valid = 1'b0;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_tx_valid", 32'(spi_tx_valid), 32'd0);
        chk("rst_tx_data", 32'(spi_tx_data), 32'h00);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0000);
        step(); step(); step();
        rst = 1'b0;
        step();

        // write 0x15 <- 0xBEEF, rx echoes the tx bytes
        xact("wr", 1'b0, 7'h15, 16'hBEEF, 8'h15, 8'hBE, 8'hEF, 8'h15, 8'hBE, 8'hEF, 16'hBEEF, 1'b0);

        // read 0x2A with cmd_valid held high while busy
        xact("rd", 1'b1, 7'h2A, 16'h5555, 8'hAA, 8'h00, 8'h00, 8'hFF, 8'h12, 8'h34, 16'h1234, 1'b1);

        // byte1 stalled for 5 cycles
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h15; cmd_wdata = 16'hBEEF; spi_tx_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("stall_b0", 32'(spi_tx_data), 32'h15);
        spi_rx_valid = 1'b1; spi_rx_data = 8'h00;
        step();
        spi_tx_ready = 1'b0; spi_rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(spi_tx_valid), 32'd1);
            chk("stall_b1_hold", 32'(spi_tx_data), 32'hBE);
            step();
        end
        spi_tx_ready = 1'b1;
        chk("stall_b1_release", 32'(spi_tx_data), 32'hBE);
        spi_rx_valid = 1'b1; spi_rx_data = 8'hAB;
        step();
        chk("stall_b2", 32'(spi_tx_data), 32'hEF);
        spi_rx_data = 8'hCD;
        step();
        spi_rx_valid = 1'b0;
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rsp_error", 32'(rsp_error), 32'd0);
        chk("stall_rsp_rdata", 32'(rsp_rdata), 32'hABCD);
        step();
        chk("stall_idle", 32'(cmd_ready), 32'd1);

        // timeout: rx strobes only with bytes 1 and 2, third strobe never comes
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h01; cmd_wdata = 16'h0000;
        step();
        cmd_valid = 1'b0;
        chk("to_b0", 32'(spi_tx_data), 32'h81);
        step();
        chk("to_b1", 32'(spi_tx_data), 32'h00);
        spi_rx_valid = 1'b1; spi_rx_data = 8'h77;
        step();
        spi_rx_data = 8'h5A;
        step();
        spi_rx_valid = 1'b0;
        chk("to_wait_tx_valid", 32'(spi_tx_valid), 32'd0);
        chk("to_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            step();
            cnt++;
        end
        chk("to_latency", 32'(cnt), 32'd16);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_error", 32'(rsp_error), 32'd1);
        chk("to_rdata_hi", 32'(rsp_rdata[15:8]), 32'h5A);
        step();
        chk("to_idle", 32'(cmd_ready), 32'd1);
        chk("to_pulse_end", 32'(rsp_valid), 32'd0);

        // reset after the byte1 handshake
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h15; cmd_wdata = 16'hBEEF;
        step();
        cmd_valid = 1'b0;
        spi_rx_valid = 1'b1; spi_rx_data = 8'h11;
        step();
        spi_rx_data = 8'h99;
        step();
        spi_rx_valid = 1'b0;
        chk("rm_b2_pending", 32'(spi_tx_data), 32'hEF);
        rst = 1'b1;
        #1;
        chk("rm_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rm_tx_valid", 32'(spi_tx_valid), 32'd0);
        chk("rm_tx_data", 32'(spi_tx_data), 32'h00);
        chk("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rm_rsp_error", 32'(rsp_error), 32'd0);
        chk("rm_rsp_rdata", 32'(rsp_rdata), 32'h0000);
        step(); step();
        rst = 1'b0;
        step();
        chk("rm_no_rsp", 32'(rsp_valid), 32'd0);
        xact("rm_rd", 1'b1, 7'h2A, 16'h0000, 8'hAA, 8'h00, 8'h00, 8'hFF, 8'h12, 8'h34, 16'h1234, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
